register_file_scoreboard: RTL and testbench

Parametrised multi-read-port register file with a per-register pending-write scoreboard, for the pipelined datapath. It generalises the fixed 32x32, two-read-port file:
- width, depth and read-port count are set by parameters;
- storage clears on reset;
- each register carries a busy bit, so issue logic can detect read-after-write hazards against in-flight producers;
- optional same-cycle write-to-read bypass.

---
 rtl/register_file_scoreboard.sv | 73 +++++++
 tb/tb_register_file_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_scoreboard.sv
// Parametrised multi-read-port register file with a per-register pending-write (busy) scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy state) to matching read ports.
module register_file_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       writeEnable,
  input  logic [ADDR_W-1:0]          regWriteSel,
  input  logic [DATA_W-1:0]          writeData,
  input  logic                       reserveEnable,
  input  logic [ADDR_W-1:0]          reserveSel,
  input  logic [NUM_READ*ADDR_W-1:0] regReadSel,
  output logic [NUM_READ*DATA_W-1:0] regReadData,
  output logic [NUM_READ-1:0]        regBusy
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic w_wr_ok;
  logic w_rs_ok;

  // Register 0 and addresses beyond DEPTH-1 never accept writes or reserves.
  assign w_wr_ok = writeEnable   && (regWriteSel != '0) && (32'(regWriteSel) < DEPTH);
  assign w_rs_ok = reserveEnable && (reserveSel  != '0) && (32'(reserveSel)  < DEPTH);

  // Storage and scoreboard; the reserve is applied last so a newer producer wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[regWriteSel]  <= writeData;
        r_busy[regWriteSel] <= 1'b0;
      end
      if (w_rs_ok) begin
        r_busy[reserveSel] <= 1'b1;
      end
    end
  end

  // Independent combinational read ports.
  for (genvar gp = 0; gp < int'(NUM_READ); gp++) begin : g_rd
    logic [ADDR_W-1:0] w_sel;
    logic              w_ok;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    assign w_sel  = regReadSel[gp*ADDR_W +: ADDR_W];
    assign w_ok   = (w_sel != '0) && (32'(w_sel) < DEPTH);
    assign w_data = w_ok ? r_mem[w_sel] : '0;
    assign w_busy = w_ok & r_busy[w_sel];

`ifdef REGFILE_BYPASS_EN
    logic w_byp;
    // Gated by rst so an in-flight write never leaks through while reset is held.
    assign w_byp = rst && w_wr_ok && (w_sel == regWriteSel);
    assign regReadData[gp*DATA_W +: DATA_W] = w_byp ? writeData : w_data;
    assign regBusy[gp] = w_byp ? (w_rs_ok && (reserveSel == regWriteSel)) : w_busy;
`else
    assign regReadData[gp*DATA_W +: DATA_W] = w_data;
    assign regBusy[gp] = w_busy;
`endif
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Self-checking bench for register_file_scoreboard: directed scenarios plus random traffic
// compared against an array-based model of the register file and its busy scoreboard.
module tb_register_file_scoreboard;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 24;
  localparam int unsigned NR    = 3;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst;
  logic             writeEnable;
  logic [AW-1:0]    regWriteSel;
  logic [DW-1:0]    writeData;
  logic             reserveEnable;
  logic [AW-1:0]    reserveSel;
  logic [NR*AW-1:0] regReadSel;
  logic [NR*DW-1:0] regReadData;
  logic [NR-1:0]    regBusy;

  register_file_scoreboard #(
    .DATA_W(DW), .DEPTH(DEPTH), .NUM_READ(NR), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .writeEnable(writeEnable), .regWriteSel(regWriteSel), .writeData(writeData),
    .reserveEnable(reserveEnable), .reserveSel(reserveSel),
    .regReadSel(regReadSel), .regReadData(regReadData), .regBusy(regBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit valid_addr(input int a);
    return (a != 0) && (a < int'(DEPTH));
  endfunction

  function automatic bit bypass_hit(input int a);
`ifdef REGFILE_BYPASS_EN
    return rst && writeEnable && valid_addr(int'(regWriteSel)) && (int'(regWriteSel) == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input int a);
    if (!valid_addr(a)) return '0;
    if (bypass_hit(a)) return writeData;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!valid_addr(a)) return 1'b0;
    if (bypass_hit(a)) return reserveEnable && (reserveSel == regWriteSel);
    return m_busy[a];
  endfunction

  task automatic set_rd(input int p, input int a);
    regReadSel[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [DW-1:0] rd_data(input int p);
    return regReadData[p*DW +: DW];
  endfunction

  task automatic check_ports(input string tag);
    for (int p = 0; p < int'(NR); p++) begin
      int a;
      a = int'(regReadSel[p*AW +: AW]);
      chk($sformatf("%s_d%0d_r%0d", tag, p, a), 64'(rd_data(p)), 64'(exp_data(a)));
      chk($sformatf("%s_b%0d_r%0d", tag, p, a), 64'(regBusy[p]), 64'(exp_busy(a)));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clock: the model commits from the inputs held across the rising edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      if (writeEnable && valid_addr(int'(regWriteSel))) begin
        m_mem[regWriteSel]  = writeData;
        m_busy[regWriteSel] = 1'b0;
      end
      if (reserveEnable && valid_addr(int'(reserveSel)))
        m_busy[reserveSel] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    writeEnable   = 1'b0;
    reserveEnable = 1'b0;
  endtask

  initial begin
    model_clear();
    rst = 1'b0;
    writeEnable = 1'b1; regWriteSel = AW'(5); writeData = 32'h1111_1111;
    reserveEnable = 1'b1; reserveSel = AW'(5);
    regReadSel = '0;
    set_rd(0, 5); set_rd(1, 5); set_rd(2, 0);

    // Reset held with a pending write/reserve to r5: nothing may land.
    cycle(); cycle();
    #1;
    chk("rst_hold_r5_data", 64'(rd_data(0)), 64'h0);
    chk("rst_hold_r5_busy", 64'(regBusy[0]), 64'h0);
    idle();
    rst = 1'b1;
    #1;
    check_ports("rst_rel");
    chk("rst_rel_r5_data", 64'(rd_data(1)), 64'h0);

    // Write/readback and r0 write ignored.
    writeEnable = 1'b1; regWriteSel = AW'(7); writeData = 32'hDEAD_BEEF;
    cycle();
    regWriteSel = AW'(0);
    cycle();
    idle();
    set_rd(0, 7); set_rd(1, 0);
    #1;
    chk("wr_r7", 64'(rd_data(0)), 64'hDEAD_BEEF);
    chk("wr_r0", 64'(rd_data(1)), 64'h0);
    chk("r0_busy", 64'(regBusy[1]), 64'h0);

    // Scoreboard lifecycle on r3.
    reserveEnable = 1'b1; reserveSel = AW'(3);
    cycle();
    idle();
    set_rd(0, 3);
    #1;
    chk("rsv_r3_busy", 64'(regBusy[0]), 64'h1);
    writeEnable = 1'b1; regWriteSel = AW'(3); writeData = 32'h12;
    cycle();
    idle();
    #1;
    chk("wr_r3_busy", 64'(regBusy[0]), 64'h0);
    chk("wr_r3_data", 64'(rd_data(0)), 64'h12);
    writeEnable = 1'b1; regWriteSel = AW'(3); writeData = 32'h34;
    reserveEnable = 1'b1; reserveSel = AW'(3);
    cycle();
    idle();
    #1;
    chk("wrrsv_r3_data", 64'(rd_data(0)), 64'h34);
    chk("wrrsv_r3_busy", 64'(regBusy[0]), 64'h1);

    // Same-cycle read of a register being written.
    set_rd(1, 9);
    writeEnable = 1'b1; regWriteSel = AW'(9); writeData = 32'hA5A5_A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_r9_data", 64'(rd_data(1)), 64'hA5A5_A5A5);
`else
    chk("byp_r9_data", 64'(rd_data(1)), 64'h0);
`endif
    chk("byp_r9_busy", 64'(regBusy[1]), 64'h0);
    check_ports("byp");
    cycle();
    idle();
    #1;
    chk("post_r9_data", 64'(rd_data(1)), 64'hA5A5_A5A5);

    // Asynchronous reset between edges.
    @(negedge clk);
    writeEnable = 1'b1; regWriteSel = AW'(2); writeData = 32'h55;
    reserveEnable = 1'b1; reserveSel = AW'(2);
    cycle();
    idle();
    set_rd(0, 2);
    #1;
    chk("mid_r2_data", 64'(rd_data(0)), 64'h55);
    chk("mid_r2_busy", 64'(regBusy[0]), 64'h1);
    #1 rst = 1'b0;
    #1;
    chk("async_r2_data", 64'(rd_data(0)), 64'h0);
    chk("async_r2_busy", 64'(regBusy[0]), 64'h0);
    model_clear();
    check_ports("async");
    rst = 1'b1;
    @(negedge clk);

    // Out-of-range address and all ports on the top register.
    writeEnable = 1'b1; regWriteSel = AW'(30); writeData = 32'hFFFF_FFFF;
    reserveEnable = 1'b1; reserveSel = AW'(30);
    set_rd(0, 30);
    cycle();
    idle();
    #1;
    chk("oor_r30_data", 64'(rd_data(0)), 64'h0);
    chk("oor_r30_busy", 64'(regBusy[0]), 64'h0);
    writeEnable = 1'b1; regWriteSel = AW'(DEPTH - 1); writeData = 32'hCAFE_F00D;
    cycle();
    idle();
    for (int p = 0; p < int'(NR); p++) set_rd(p, int'(DEPTH) - 1);
    #1;
    for (int p = 0; p < int'(NR); p++)
      chk($sformatf("top_reg_p%0d", p), 64'(rd_data(p)), 64'hCAFE_F00D);

    // Random traffic including r0 and out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      writeEnable   = 1'($urandom_range(0, 1));
      regWriteSel   = AW'($urandom_range(0, 31));
      writeData     = DW'($urandom);
      reserveEnable = 1'($urandom_range(0, 2) == 0);
      reserveSel    = (($urandom_range(0, 3) == 0) ? regWriteSel : AW'($urandom_range(0, 31)));
      for (int p = 0; p < int'(NR); p++)
        set_rd(p, ($urandom_range(0, 2) == 0) ? int'(regWriteSel) : int'($urandom_range(0, 31)));
      #1;
      check_ports("rnd");
      cycle();
    end

    idle();
    #1;
    for (int a = 0; a < 32; a++) begin
      set_rd(0, a);
      #1;
      check_ports("final");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
